// File: rtl/nibble_add_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-serial adder sequencer.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_cnt(input int data_w);
    return data_w / NIB_W;
  endfunction

  // Counter width for NIB_CNT nibbles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nib_shreg.sv
// Parallel-load register shifting right by one nibble per enabled cycle, shift_in entering at the top.
module nib_shreg
  import nibble_add_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     load_val,
  input  logic [NIB_W-1:0] shift_in,
  output logic [W-1:0]     q
);

  logic [W-1:0] shifted;

  if (W > NIB_W) begin : g_wide
    assign shifted = {shift_in, q[W-1:NIB_W]};
  end else begin : g_narrow
    assign shifted = shift_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/nibble_serial_add_seq.sv
// DATA_W-bit add, one nibble per cycle through an external slice; result valid NIB_CNT edges after intake,
// held until out_ready. NIBBLE_ADD_OVF_EN adds the signed-overflow output out_ovf.
module nibble_serial_add_seq
  import nibble_add_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  output logic [NIB_W-1:0]  add_a,
  output logic [NIB_W-1:0]  add_b,
  output logic              add_cin,
  input  logic [NIB_W-1:0]  add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic              out_ovf
`endif
);

  localparam int NIB_CNT = nib_cnt(DATA_W);
  localparam int CNT_W   = cnt_width(NIB_CNT);

  if (((DATA_W % NIB_W) != 0) || (DATA_W < NIB_W)) begin : g_bad_width
    $error("DATA_W must be a positive multiple of 4");
  end

  state_t             state_q, state_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  a_q, b_q, s_q;
  logic               load, shift, last;

  assign last = (cnt_q == CNT_W'(NIB_CNT - 1));

  nib_shreg #(.W(DATA_W)) u_a_sh (
    .clk(clk), .rst(rst), .load(load), .shift(shift),
    .load_val(in_a), .shift_in('0), .q(a_q)
  );

  nib_shreg #(.W(DATA_W)) u_b_sh (
    .clk(clk), .rst(rst), .load(load), .shift(shift),
    .load_val(in_b), .shift_in('0), .q(b_q)
  );

  // Sum nibbles enter at the top so the first one lands at bit 0 after NIB_CNT shifts.
  nib_shreg #(.W(DATA_W)) u_sum_sh (
    .clk(clk), .rst(rst), .load(load), .shift(shift),
    .load_val('0), .shift_in(add_sum), .q(s_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        carry_q <= in_cin;
        cnt_q   <= '0;
      end else if (shift) begin
        carry_q <= add_cout;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[NIB_W-1:0];
        add_b   = b_q[NIB_W-1:0];
        add_cin = carry_q;
        shift   = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = s_q;
        out_cout  = carry_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NIBBLE_ADD_OVF_EN
  logic ovf_q;

  // On the last nibble a_q/b_q hold the operand sign bits; overflow is carry-in xor carry-out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (shift && last) begin
      ovf_q <= a_q[NIB_W-1] ^ b_q[NIB_W-1] ^ add_sum[NIB_W-1] ^ add_cout;
    end
  end

  assign out_ovf = (state_q == DONE) & ovf_q;
`endif

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
- Sequencer that performs a DATA_W-bit add one 4-bit nibble per cycle through an external combinational 4-bit ripple adder slice.
- Upstream side: valid/ready operand intake. Downstream side: valid/ready result delivery.
- Drives the slice's a/b/cin inputs, consumes its sum/cout, and holds the inter-nibble carry in a register.
- Lets the datapath reuse one small adder for wide operands.

Parameters:
- DATA_W, 16, operand/result width; must be a multiple of 4 and ≥4 (elaboration error otherwise).
- NIB_CNT, DATA_W/4, derived; nibbles per operation; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept operands.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_cin  in  1  initial carry-in.
- add_a  out  4  current A nibble to adder slice.
- add_b  out  4  current B nibble to adder slice.
- add_cin  out  1  carry to adder slice.
- add_sum  in  4  slice sum, combinational, same cycle.
- add_cout  in  1  slice carry-out, combinational, same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  DATA_W  assembled sum.
- out_cout  out  1  final carry-out.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0, add_cin=0, internal shift registers, carry and counter all 0.
- State IDLE:
  - in_ready=1.
  - On in_valid at an edge: load a_sh=in_a, b_sh=in_b, carry_q=in_cin, sum_sh=0, cnt=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Outputs are driven from registers only: add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry_q.
  - Each edge: sum_sh <= {add_sum, sum_sh[DATA_W-1:4]}; a_sh, b_sh shift right by 4 with zero fill; carry_q <= add_cout; cnt++.
  - At the edge where cnt==NIB_CNT-1: go to DONE.
- State DONE:
  - out_valid=1, out_sum=sum_sh, out_cout=carry_q, in_ready=0.
  - out_sum and out_cout are held stable while out_ready=0, with no limit on stall length.
  - On out_ready at an edge: go to IDLE.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Latency: operand handshake at edge k gives out_valid high from edge k+NIB_CNT. Minimum initiation interval is NIB_CNT+2 cycles.
- Arithmetic: result equals (in_a + in_b + in_cin) mod 2^DATA_W; out_cout is bit DATA_W of that sum.
- No overlap: in_valid is ignored outside IDLE. The producer must hold its operands until in_ready.
- Reset mid-operation (RUN or DONE): the operation is abandoned with no output, and all reset values apply on the next cycle.
- NIB_CNT==1 (DATA_W=4): RUN lasts exactly one cycle.

Optional Feature:
- Macro: NIBBLE_ADD_OVF_EN.
- When defined:
  - Extra port out_ovf (out, 1) gives signed two's-complement overflow.
  - On the final RUN edge, ovf_q <= a_sh[3]^b_sh[3]^add_sum[3]^add_cout.
  - out_ovf is valid with out_valid, reset 0, and is 0 outside DONE.
- When undefined: the port and the logic are absent. All other behaviour is identical.

Decomposition:
- Shared package nibble_add_pkg holds: NIB_W=4; state typedef (IDLE, RUN, DONE; 2-bit encoding); function computing NIB_CNT from DATA_W; count-width constant, i.e. clog2 of NIB_CNT, minimum 1.
- One natural sub-module: nib_shreg, a parameterised DATA_W shift-right-by-NIB_W register with parallel load. It is instantiated three times, for A, B and the sum (the sum copy shifts in at the top).

Test Plan (DATA_W=16):
- 0x1234 + 0x0FFF, cin=0 -> out_sum=0x2233, out_cout=0. out_valid rises exactly 4 edges after acceptance. add_a sequence is 4,3,2,1.
- 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1. add_cin sequence is 0,1,1,1.
- 0x7FFF + 0x0000, cin=1 -> out_sum=0x8000, out_cout=0. With NIBBLE_ADD_OVF_EN, out_ovf=1. Also 0x8000+0x8000 -> out_sum=0x0000, out_cout=1, out_ovf=1.
- Hold out_ready=0 for 10 cycles in DONE -> out_sum and out_valid stable, in_ready=0, and a new in_valid is ignored. Release -> IDLE, then the next operand is accepted.
- Assert rst for 1 cycle in the second RUN cycle of 0xAAAA+0x5555 -> all outputs at reset values next cycle, and no out_valid pulse. A following 0x0001+0x0001 -> 0x0002.
- Back-to-back: in_valid held high with out_ready=1 throughout -> each result appears every 6 cycles, and operands are latched only when in_ready=1.
